// File: rtl/bru_if.sv
// Branch resolution bus: per-channel issue/result handshakes, kill/clear
// broadcasts, ROB head and the single recovery request.
interface bru_if #(
  parameter int XLEN      = 32,
  parameter int NUM_CH    = 3,
  parameter int ROB_IDX_W = 6,
  parameter int BR_MASK_W = 4
);
  logic [NUM_CH-1:0]                 in_valid;
  logic [NUM_CH-1:0]                 in_ready;
  logic [NUM_CH-1:0][XLEN-1:0]       in_rs1;
  logic [NUM_CH-1:0][XLEN-1:0]       in_rs2;
  logic [NUM_CH-1:0][XLEN-1:0]       in_pc;
  logic [NUM_CH-1:0][XLEN-1:0]       in_imm;
  logic [NUM_CH-1:0][2:0]            in_funct3;
  logic [NUM_CH-1:0]                 in_is_cond;
  logic [NUM_CH-1:0]                 in_is_jal;
  logic [NUM_CH-1:0]                 in_is_jalr;
  logic [NUM_CH-1:0]                 in_pred_taken;
  logic [NUM_CH-1:0][XLEN-1:0]       in_pred_target;
  logic [NUM_CH-1:0][ROB_IDX_W-1:0]  in_rob_idx;
  logic [NUM_CH-1:0][BR_MASK_W-1:0]  in_br_mask;
  logic                              kill_valid;
  logic [BR_MASK_W-1:0]              kill_mask;
  logic                              clear_valid;
  logic [BR_MASK_W-1:0]              clear_mask;
  logic [ROB_IDX_W-1:0]              rob_head;
  logic [NUM_CH-1:0]                 out_valid;
  logic [NUM_CH-1:0]                 out_ready;
  logic [NUM_CH-1:0]                 out_taken;
  logic [NUM_CH-1:0][XLEN-1:0]       out_next_pc;
  logic [NUM_CH-1:0][XLEN-1:0]       out_link;
  logic [NUM_CH-1:0]                 out_mispredict;
  logic [NUM_CH-1:0][ROB_IDX_W-1:0]  out_rob_idx;
  logic                              recover_valid;
  logic [XLEN-1:0]                   recover_pc;
  logic [ROB_IDX_W-1:0]              recover_rob_idx;

  modport master (
    output in_valid, in_rs1, in_rs2, in_pc, in_imm, in_funct3, in_is_cond,
           in_is_jal, in_is_jalr, in_pred_taken, in_pred_target, in_rob_idx,
           in_br_mask, kill_valid, kill_mask, clear_valid, clear_mask,
           rob_head, out_ready,
    input  in_ready, out_valid, out_taken, out_next_pc, out_link,
           out_mispredict, out_rob_idx, recover_valid, recover_pc,
           recover_rob_idx
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_pc, in_imm, in_funct3, in_is_cond,
           in_is_jal, in_is_jalr, in_pred_taken, in_pred_target, in_rob_idx,
           in_br_mask, kill_valid, kill_mask, clear_valid, clear_mask,
           rob_head, out_ready,
    output in_ready, out_valid, out_taken, out_next_pc, out_link,
           out_mispredict, out_rob_idx, recover_valid, recover_pc,
           recover_rob_idx
  );
endinterface

// File: rtl/bru_pipe.sv
// Pipelined multi-channel branch resolution unit: two valid/ready stages per
// channel, branch-mask kill/clear, and oldest-mispredict recovery select.
module bru_pipe #(
  parameter int XLEN      = 32,
  parameter int NUM_CH    = 3,
  parameter int ROB_IDX_W = 6,
  parameter int BR_MASK_W = 4
) (
  input logic clock,
  input logic reset,
  bru_if.slave bus
);

  logic [NUM_CH-1:0]                vld_p1, vld_p2;
  logic [NUM_CH-1:0][XLEN-1:0]      rs1_p1, rs2_p1, pc_p1, imm_p1, ptgt_p1;
  logic [NUM_CH-1:0][2:0]           f3_p1;
  logic [NUM_CH-1:0]                cond_p1, jal_p1, jalr_p1, ptk_p1;
  logic [NUM_CH-1:0][ROB_IDX_W-1:0] rob_p1, rob_p2;
  logic [NUM_CH-1:0][BR_MASK_W-1:0] mask_p1, mask_p2;
  logic [NUM_CH-1:0]                taken_p2, mp_p2;
  logic [NUM_CH-1:0][XLEN-1:0]      npc_p2, link_p2;

  logic [NUM_CH-1:0]                adv_p1, adv_p2, kill_p1, kill_p2, kill_in;
  logic [NUM_CH-1:0]                taken_c, mp_c;
  logic [NUM_CH-1:0][XLEN-1:0]      tgt_c, link_c, npc_c, ppc_c;
  logic [BR_MASK_W-1:0]             clr_keep;

  logic [NUM_CH-1:0][ROB_IDX_W-1:0] age_c;
  logic [ROB_IDX_W-1:0]             best_age;
  logic                             rec_vld;
  logic [XLEN-1:0]                  rec_pc;
  logic [ROB_IDX_W-1:0]             rec_idx;

  function automatic logic cond_eval(input logic [2:0] f3,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  assign clr_keep = bus.clear_valid ? ~bus.clear_mask : {BR_MASK_W{1'b1}};

  always_comb begin
    adv_p1  = '0;
    adv_p2  = '0;
    kill_p1 = '0;
    kill_p2 = '0;
    kill_in = '0;
    taken_c = '0;
    mp_c    = '0;
    tgt_c   = '0;
    link_c  = '0;
    npc_c   = '0;
    ppc_c   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      adv_p2[c]  = !vld_p2[c] | bus.out_ready[c];
      adv_p1[c]  = !vld_p1[c] | adv_p2[c];
      kill_p1[c] = bus.kill_valid & (|(mask_p1[c] & bus.kill_mask));
      kill_p2[c] = bus.kill_valid & (|(mask_p2[c] & bus.kill_mask));
      kill_in[c] = bus.kill_valid & (|(bus.in_br_mask[c] & bus.kill_mask));
      taken_c[c] = jal_p1[c] | jalr_p1[c] |
                   (cond_p1[c] & cond_eval(f3_p1[c], rs1_p1[c], rs2_p1[c]));
      tgt_c[c]   = jalr_p1[c] ? ((rs1_p1[c] + imm_p1[c]) & ~XLEN'(1))
                              : (pc_p1[c] + imm_p1[c]);
      link_c[c]  = pc_p1[c] + XLEN'(4);
      npc_c[c]   = taken_c[c] ? tgt_c[c] : link_c[c];
      ppc_c[c]   = (ptk_p1[c] | jal_p1[c] | jalr_p1[c]) ? ptgt_p1[c] : link_c[c];
      mp_c[c]    = npc_c[c] != ppc_c[c];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p1   <= '0;
      vld_p2   <= '0;
      rs1_p1   <= '0;
      rs2_p1   <= '0;
      pc_p1    <= '0;
      imm_p1   <= '0;
      ptgt_p1  <= '0;
      f3_p1    <= '0;
      cond_p1  <= '0;
      jal_p1   <= '0;
      jalr_p1  <= '0;
      ptk_p1   <= '0;
      rob_p1   <= '0;
      mask_p1  <= '0;
      rob_p2   <= '0;
      mask_p2  <= '0;
      taken_p2 <= '0;
      mp_p2    <= '0;
      npc_p2   <= '0;
      link_p2  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        // S1: capture operands; a killed incoming uop completes its handshake but is dropped
        if (adv_p1[c]) begin
          vld_p1[c]  <= bus.in_valid[c] & !kill_in[c];
          rs1_p1[c]  <= bus.in_rs1[c];
          rs2_p1[c]  <= bus.in_rs2[c];
          pc_p1[c]   <= bus.in_pc[c];
          imm_p1[c]  <= bus.in_imm[c];
          ptgt_p1[c] <= bus.in_pred_target[c];
          f3_p1[c]   <= bus.in_funct3[c];
          cond_p1[c] <= bus.in_is_cond[c];
          jal_p1[c]  <= bus.in_is_jal[c];
          jalr_p1[c] <= bus.in_is_jalr[c];
          ptk_p1[c]  <= bus.in_pred_taken[c];
          rob_p1[c]  <= bus.in_rob_idx[c];
          mask_p1[c] <= bus.in_br_mask[c] & clr_keep;
        end else if (kill_p1[c]) begin
          vld_p1[c]  <= 1'b0;
        end else begin
          mask_p1[c] <= mask_p1[c] & clr_keep;
        end

        // S2: resolved results; kill beats the S1->S2 move
        if (adv_p2[c]) begin
          vld_p2[c]   <= vld_p1[c] & !kill_p1[c];
          taken_p2[c] <= taken_c[c];
          npc_p2[c]   <= npc_c[c];
          link_p2[c]  <= link_c[c];
          mp_p2[c]    <= mp_c[c];
          rob_p2[c]   <= rob_p1[c];
          mask_p2[c]  <= mask_p1[c] & clr_keep;
        end else if (kill_p2[c]) begin
          vld_p2[c]   <= 1'b0;
        end else begin
          mask_p2[c]  <= mask_p2[c] & clr_keep;
        end
      end
    end
  end

  // Recovery: smallest distance from the ROB head among firing mispredicts
  always_comb begin
    age_c    = '0;
    best_age = '0;
    rec_vld  = 1'b0;
    rec_pc   = '0;
    rec_idx  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      age_c[c] = rob_p2[c] - bus.rob_head;
      if (vld_p2[c] && bus.out_ready[c] && mp_p2[c] &&
          (!rec_vld || age_c[c] < best_age)) begin
        rec_vld  = 1'b1;
        best_age = age_c[c];
        rec_pc   = npc_p2[c];
        rec_idx  = rob_p2[c];
      end
    end
  end

  assign bus.in_ready        = {NUM_CH{reset}} & adv_p1;
  assign bus.out_valid       = vld_p2;
  assign bus.out_taken       = taken_p2;
  assign bus.out_next_pc     = npc_p2;
  assign bus.out_link        = link_p2;
  assign bus.out_mispredict  = mp_p2;
  assign bus.out_rob_idx     = rob_p2;
  assign bus.recover_valid   = rec_vld;
  assign bus.recover_pc      = rec_pc;
  assign bus.recover_rob_idx = rec_idx;

endmodule

// File: tb/tb_bru_pipe.sv
// Directed bench for bru_pipe: single-uop vector table on channel 0, then
// recovery select, backpressure, kill/clear and mid-flight reset sequences.
module tb_bru_pipe;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bru_if #(.XLEN(32), .NUM_CH(3), .ROB_IDX_W(6), .BR_MASK_W(4)) bus ();

  bru_pipe #(.XLEN(32), .NUM_CH(3), .ROB_IDX_W(6), .BR_MASK_W(4)) u_dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;   // 0 cond, 1 jal, 2 jalr
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_tk;
    logic [31:0] e_np;
    logic [31:0] e_lk;
    logic        e_mp;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid       = '0;
    bus.in_rs1         = '0;
    bus.in_rs2         = '0;
    bus.in_pc          = '0;
    bus.in_imm         = '0;
    bus.in_funct3      = '0;
    bus.in_is_cond     = '0;
    bus.in_is_jal      = '0;
    bus.in_is_jalr     = '0;
    bus.in_pred_taken  = '0;
    bus.in_pred_target = '0;
    bus.in_rob_idx     = '0;
    bus.in_br_mask     = '0;
    bus.kill_valid     = 1'b0;
    bus.kill_mask      = '0;
    bus.clear_valid    = 1'b0;
    bus.clear_mask     = '0;
    bus.rob_head       = '0;
    bus.out_ready      = '1;
  endtask

  task automatic drive(input int ch, input logic [1:0] kind, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic pt, input logic [31:0] ptgt,
                       input logic [5:0] rob, input logic [3:0] mask);
    bus.in_valid[ch]       = 1'b1;
    bus.in_is_cond[ch]     = (kind == 2'd0);
    bus.in_is_jal[ch]      = (kind == 2'd1);
    bus.in_is_jalr[ch]     = (kind == 2'd2);
    bus.in_funct3[ch]      = f3;
    bus.in_rs1[ch]         = rs1;
    bus.in_rs2[ch]         = rs2;
    bus.in_pc[ch]          = pc;
    bus.in_imm[ch]         = imm;
    bus.in_pred_taken[ch]  = pt;
    bus.in_pred_target[ch] = ptgt;
    bus.in_rob_idx[ch]     = rob;
    bus.in_br_mask[ch]     = mask;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] q[$];
    logic [5:0] nxt;
    logic [5:0] exp_rob;
    logic       last_rdy;
    int         acc;
    int         got;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle();

    vt[0]  = '{2'd0, 3'b000, 32'd5,        32'd5,        32'h100,      32'h20,       1'b1, 32'h120,  1'b1, 32'h120, 32'h104, 1'b0};
    vt[1]  = '{2'd0, 3'b100, 32'hFFFFFFFF, 32'd1,        32'h200,      32'h40,       1'b0, 32'h0,    1'b1, 32'h240, 32'h204, 1'b1};
    vt[2]  = '{2'd0, 3'b110, 32'hFFFFFFFF, 32'd1,        32'h200,      32'h40,       1'b0, 32'h0,    1'b0, 32'h204, 32'h204, 1'b0};
    vt[3]  = '{2'd2, 3'b000, 32'h203,      32'd0,        32'h300,      32'h0,        1'b1, 32'h202,  1'b1, 32'h202, 32'h304, 1'b0};
    vt[4]  = '{2'd0, 3'b001, 32'd5,        32'd5,        32'h400,      32'h8,        1'b1, 32'h408,  1'b0, 32'h404, 32'h404, 1'b1};
    vt[5]  = '{2'd0, 3'b101, 32'd1,        32'hFFFFFFFF, 32'h500,      32'hFFFFFFF0, 1'b1, 32'h4F0,  1'b1, 32'h4F0, 32'h504, 1'b0};
    vt[6]  = '{2'd0, 3'b111, 32'd1,        32'hFFFFFFFF, 32'h500,      32'hFFFFFFF0, 1'b1, 32'h600,  1'b0, 32'h504, 32'h504, 1'b1};
    vt[7]  = '{2'd0, 3'b010, 32'd0,        32'd0,        32'h600,      32'h4,        1'b0, 32'h0,    1'b0, 32'h604, 32'h604, 1'b0};
    vt[8]  = '{2'd1, 3'b000, 32'd0,        32'd0,        32'hFFFFFFFC, 32'h8,        1'b1, 32'h4,    1'b1, 32'h4,   32'h0,   1'b0};
    vt[9]  = '{2'd2, 3'b000, 32'h1000,     32'd0,        32'h900,      32'h11,       1'b1, 32'h1011, 1'b1, 32'h1010, 32'h904, 1'b1};
    vt[10] = '{2'd1, 3'b000, 32'd0,        32'd0,        32'h700,      32'h100,      1'b0, 32'h800,  1'b1, 32'h800, 32'h704, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_recover_valid", 64'(bus.recover_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_reset", 64'(bus.in_ready), 64'h7);

    // vector table on channel 0
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(0, vt[i].kind, vt[i].f3, vt[i].rs1, vt[i].rs2, vt[i].pc, vt[i].imm,
            vt[i].pt, vt[i].ptgt, 6'(i + 1), 4'b0000);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid[0] = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 64'(bus.out_valid[0]), 64'd1);
      chk($sformatf("v%0d_taken", i), 64'(bus.out_taken[0]), 64'(vt[i].e_tk));
      chk($sformatf("v%0d_next_pc", i), 64'(bus.out_next_pc[0]), 64'(vt[i].e_np));
      chk($sformatf("v%0d_link", i), 64'(bus.out_link[0]), 64'(vt[i].e_lk));
      chk($sformatf("v%0d_mispredict", i), 64'(bus.out_mispredict[0]), 64'(vt[i].e_mp));
      chk($sformatf("v%0d_rob_idx", i), 64'(bus.out_rob_idx[0]), 64'(i + 1));
      chk($sformatf("v%0d_recover_valid", i), 64'(bus.recover_valid), 64'(vt[i].e_mp));
      chk($sformatf("v%0d_recover_pc", i), 64'(bus.recover_pc),
          vt[i].e_mp ? 64'(vt[i].e_np) : 64'd0);
      chk($sformatf("v%0d_recover_rob", i), 64'(bus.recover_rob_idx),
          vt[i].e_mp ? 64'(i + 1) : 64'd0);
    end

    // three simultaneous mispredicts, oldest relative to rob_head wins
    @(negedge clk);
    idle();
    drive(0, 2'd0, 3'b000, 32'd1, 32'd1, 32'h1000, 32'h10, 1'b0, 32'h0, 6'd10, 4'b0);
    drive(1, 2'd0, 3'b000, 32'd1, 32'd1, 32'h2000, 32'h10, 1'b0, 32'h0, 6'd3,  4'b0);
    drive(2, 2'd0, 3'b000, 32'd1, 32'd1, 32'h3000, 32'h10, 1'b0, 32'h0, 6'd60, 4'b0);
    bus.rob_head = 6'd58;
    @(negedge clk);
    bus.in_valid = '0;
    @(posedge clk);
    #1;
    chk("rec3_out_valid", 64'(bus.out_valid), 64'h7);
    chk("rec3_valid", 64'(bus.recover_valid), 64'd1);
    chk("rec3_rob_idx", 64'(bus.recover_rob_idx), 64'd60);
    chk("rec3_pc", 64'(bus.recover_pc), 64'h3010);
    bus.out_ready[2] = 1'b0;
    #1;
    chk("rec2_rob_idx", 64'(bus.recover_rob_idx), 64'd3);
    chk("rec2_pc", 64'(bus.recover_pc), 64'h2010);
    bus.out_ready[2] = 1'b1;
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    chk("rec_drained", 64'(bus.out_valid), 64'd0);

    // backpressure: 4 stalled cycles, then release and drain
    idle();
    bus.out_ready[0] = 1'b0;
    acc = 0;
    nxt = 6'd20;
    last_rdy = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      drive(0, 2'd1, 3'b000, 32'd0, 32'd0, 32'h100, 32'h8, 1'b0, 32'h108, nxt, 4'b0);
      #1;
      last_rdy = bus.in_ready[0];
      if (bus.in_ready[0]) begin
        q.push_back(nxt);
        nxt++;
        acc++;
      end
    end
    chk("bp_accepts_stalled", 64'(acc), 64'd2);
    chk("bp_in_ready_low", 64'(last_rdy), 64'd0);
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
      @(negedge clk);
      bus.out_ready[0] = 1'b1;
      if (acc < 6)
        drive(0, 2'd1, 3'b000, 32'd0, 32'd0, 32'h100, 32'h8, 1'b0, 32'h108, nxt, 4'b0);
      else
        bus.in_valid[0] = 1'b0;
      #1;
      if (cyc == 0) chk("bp_release_no_bubble", 64'(bus.in_ready[0]), 64'd1);
      if (bus.out_valid[0]) begin
        if (q.size() == 0) begin
          chk("bp_extra_output", 64'(bus.out_rob_idx[0]), 64'h3F_0000);
        end else begin
          exp_rob = q.pop_front();
          chk("bp_order", 64'(bus.out_rob_idx[0]), 64'(exp_rob));
          got++;
        end
      end
      if (bus.in_valid[0] && bus.in_ready[0]) begin
        q.push_back(nxt);
        nxt++;
        acc++;
      end
    end
    chk("bp_received", 64'(got), 64'd6);
    @(negedge clk);
    idle();
    #1;
    chk("bp_no_duplicate", 64'(bus.out_valid[0]), 64'd0);

    // kill S1 (mask 0010) while clearing bit 0 from S2 (mask 0001)
    @(negedge clk);
    idle();
    bus.out_ready[0] = 1'b0;
    drive(0, 2'd1, 3'b000, 32'd0, 32'd0, 32'h100, 32'h8, 1'b0, 32'h108, 6'd40, 4'b0001);
    @(negedge clk);
    drive(0, 2'd1, 3'b000, 32'd0, 32'd0, 32'h100, 32'h8, 1'b0, 32'h108, 6'd41, 4'b0010);
    @(negedge clk);
    bus.in_valid[0]  = 1'b0;
    bus.kill_valid   = 1'b1;
    bus.kill_mask    = 4'b0010;
    bus.clear_valid  = 1'b1;
    bus.clear_mask   = 4'b0001;
    #1;
    chk("kc_s2_present", 64'(bus.out_rob_idx[0]), 64'd40);
    @(negedge clk);
    bus.kill_mask    = 4'b0001;
    bus.clear_valid  = 1'b0;
    #1;
    chk("kc_s2_held", 64'(bus.out_valid[0]), 64'd1);
    @(negedge clk);
    bus.kill_valid   = 1'b0;
    bus.out_ready[0] = 1'b1;
    #1;
    chk("kc_s2_mask_cleared", 64'(bus.out_valid[0]), 64'd1);
    chk("kc_s2_rob", 64'(bus.out_rob_idx[0]), 64'd40);
    @(negedge clk);
    #1;
    chk("kc_s1_dropped", 64'(bus.out_valid[0]), 64'd0);

    // incoming uop matching kill: handshake completes, nothing loaded
    @(negedge clk);
    idle();
    drive(0, 2'd1, 3'b000, 32'd0, 32'd0, 32'h100, 32'h8, 1'b0, 32'h108, 6'd50, 4'b0100);
    bus.kill_valid = 1'b1;
    bus.kill_mask  = 4'b0100;
    #1;
    chk("inkill_ready", 64'(bus.in_ready[0]), 64'd1);
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    chk("inkill_not_loaded", 64'(bus.out_valid[0]), 64'd0);

    // reset with a uop in flight
    @(negedge clk);
    idle();
    drive(0, 2'd1, 3'b000, 32'd0, 32'd0, 32'h100, 32'h8, 1'b0, 32'h108, 6'd33, 4'b0);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_out_valid", 64'(bus.out_valid[0]), 64'd0);
    chk("rstmid_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstmid_in_ready_after", 64'(bus.in_ready), 64'h7);
    @(negedge clk);
    #1;
    chk("rstmid_discarded", 64'(bus.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
